// File: rtl/detect_pattern_pkg.sv
// Shared types and helpers for the detector test-pattern generator.
// Words are built at full 32-bit width and truncated by the user.
package detect_pattern_pkg;

    localparam int MAX_WIDTH = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ZERO,
        ST_ONES,
        ST_WALK1,
        ST_WALK0,
        ST_ALT,
        ST_DONE
    } state_e;

    // Number of words in one complete pattern sequence.
    function automatic int seq_len(input int w);
        return 2 * w + 4;
    endfunction

    // 1010... pattern of width w with the MSB (bit w-1) set.
    function automatic logic [MAX_WIDTH-1:0] alt_pattern(input int w);
        logic [MAX_WIDTH-1:0] p;
        p = '0;
        for (int b = 0; b < MAX_WIDTH; b++) begin
            if (b < w && ((b % 2) == ((w - 1) % 2))) begin
                p[b] = 1'b1;
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/detect_pattern_gen_walk_shift_reg.sv
// Walking-bit word source: load 0..01 or 1..10, then shift left with a
// sticky fill bit, so WALK1/WALK0 words need no barrel shifter.
module walk_shift_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_one_i,
    input  logic             load_zero_i,
    input  logic             shift_i,
    output logic [WIDTH-1:0] word_nxt_o
);

    logic [WIDTH-1:0] word_q, word_d;
    logic             fill_q, fill_d;

    always_comb begin
        word_d = word_q;
        fill_d = fill_q;
        if (load_one_i) begin
            word_d = WIDTH'(1);
            fill_d = 1'b0;
        end else if (load_zero_i) begin
            word_d = ~WIDTH'(1);
            fill_d = 1'b1;
        end else if (shift_i) begin
            word_d = {word_q[WIDTH-2:0], fill_q};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            word_q <= '0;
            fill_q <= 1'b0;
        end else begin
            word_q <= word_d;
            fill_q <= fill_d;
        end
    end

    // Next-cycle value lets the top register the word in the same edge.
    assign word_nxt_o = word_d;

endmodule

// File: rtl/detect_pattern_gen.sv
// Sequenced test-pattern transmitter for the all-zero/all-one detectors;
// each word carries its expected detector flags over valid/ready.
module detect_pattern_gen
    import detect_pattern_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic             ready,
    output logic             valid,
    output logic [WIDTH-1:0] data,
    output logic             exp_zero,
    output logic             exp_one,
    output logic             busy,
    output logic             done
);

    localparam int                   IW       = $clog2(WIDTH) + 1;
    localparam logic [IW-1:0]        IDX_LAST = IW'(WIDTH - 1);
    localparam logic [MAX_WIDTH-1:0] ALT_FULL = alt_pattern(WIDTH);
    localparam logic [WIDTH-1:0]     ALT_A    = ALT_FULL[WIDTH-1:0];

    state_e           state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             exp_zero_q, exp_zero_d;
    logic             exp_one_q, exp_one_d;
    logic             done_q, done_d;

    logic             hs;
    logic             load;
    logic [WIDTH-1:0] word;
    logic             walk_load_one, walk_load_zero, walk_shift;
    logic [WIDTH-1:0] walk_nxt;

    walk_shift_reg #(.WIDTH(WIDTH)) u_walk (
        .clk         (clk),
        .reset       (reset),
        .load_one_i  (walk_load_one),
        .load_zero_i (walk_load_zero),
        .shift_i     (walk_shift),
        .word_nxt_o  (walk_nxt)
    );

    assign hs = valid_q & ready;

    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        valid_d        = valid_q;
        done_d         = 1'b0;
        load           = 1'b0;
        word           = data_q;
        walk_load_one  = 1'b0;
        walk_load_zero = 1'b0;
        walk_shift     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_ZERO;
                    valid_d = 1'b1;
                    load    = 1'b1;
                    word    = '0;
                end
            end
            ST_ZERO: begin
                if (hs) begin
                    state_d = ST_ONES;
                    load    = 1'b1;
                    word    = '1;
                end
            end
            ST_ONES: begin
                if (hs) begin
                    state_d       = ST_WALK1;
                    idx_d         = '0;
                    walk_load_one = 1'b1;
                    load          = 1'b1;
                    word          = walk_nxt;
                end
            end
            ST_WALK1: begin
                if (hs) begin
                    load = 1'b1;
                    word = walk_nxt;
                    if (idx_q == IDX_LAST) begin
                        state_d        = ST_WALK0;
                        idx_d          = '0;
                        walk_load_zero = 1'b1;
                    end else begin
                        idx_d      = idx_q + 1'b1;
                        walk_shift = 1'b1;
                    end
                end
            end
            ST_WALK0: begin
                if (hs) begin
                    load = 1'b1;
                    if (idx_q == IDX_LAST) begin
                        state_d = ST_ALT;
                        idx_d   = '0;
                        word    = ALT_A;
                    end else begin
                        idx_d      = idx_q + 1'b1;
                        walk_shift = 1'b1;
                        word       = walk_nxt;
                    end
                end
            end
            ST_ALT: begin
                if (hs) begin
                    if (idx_q == IW'(1)) begin
                        state_d = ST_DONE;
                        valid_d = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        idx_d = IW'(1);
                        load  = 1'b1;
                        word  = ~ALT_A;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
            end
        endcase

        // Abort beats a same-cycle handshake: the in-flight word is dropped.
        if (abort && state_q != ST_IDLE) begin
            state_d        = ST_IDLE;
            idx_d          = '0;
            valid_d        = 1'b0;
            done_d         = 1'b0;
            load           = 1'b0;
            walk_load_one  = 1'b0;
            walk_load_zero = 1'b0;
            walk_shift     = 1'b0;
        end

        data_d     = data_q;
        exp_zero_d = exp_zero_q;
        exp_one_d  = exp_one_q;
        if (load) begin
            data_d     = word;
            exp_zero_d = ~|word;
            exp_one_d  = &word;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            valid_q    <= 1'b0;
            data_q     <= '0;
            exp_zero_q <= 1'b0;
            exp_one_q  <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            valid_q    <= valid_d;
            data_q     <= data_d;
            exp_zero_q <= exp_zero_d;
            exp_one_q  <= exp_one_d;
            done_q     <= done_d;
        end
    end

    assign valid    = valid_q;
    assign data     = data_q;
    assign exp_zero = exp_zero_q;
    assign exp_one  = exp_one_q;
    assign done     = done_q;
    assign busy     = (state_q != ST_IDLE) && (state_q != ST_DONE);

endmodule

// File: tb/tb_detect_pattern_gen.sv
// Directed bench for detect_pattern_gen at WIDTH=8 and WIDTH=2.
module tb_detect_pattern_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       start8, abort8, ready8;
    logic       valid8, ez8, eo8, busy8, done8;
    logic [7:0] data8;
    logic       start2, abort2, ready2;
    logic       valid2, ez2, eo2, busy2, done2;
    logic [1:0] data2;

    int checks   = 0;
    int failures = 0;

    logic [7:0] exp8 [20] = '{8'h00, 8'hFF, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                              8'h20, 8'h40, 8'h80, 8'hFE, 8'hFD, 8'hFB, 8'hF7,
                              8'hEF, 8'hDF, 8'hBF, 8'h7F, 8'hAA, 8'h55};
    logic [1:0] exp2 [8]  = '{2'd0, 2'd3, 2'd1, 2'd2, 2'd2, 2'd1, 2'd2, 2'd1};

    detect_pattern_gen #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .abort(abort8), .ready(ready8),
        .valid(valid8), .data(data8), .exp_zero(ez8), .exp_one(eo8),
        .busy(busy8), .done(done8)
    );

    detect_pattern_gen #(.WIDTH(2)) dut2 (
        .clk(clk), .reset(reset), .start(start2), .abort(abort2), .ready(ready2),
        .valid(valid2), .data(data2), .exp_zero(ez2), .exp_one(eo2),
        .busy(busy2), .done(done2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Entered at a negedge with the first word (00) on the bus; returns at
    // the negedge of the done cycle. mode 0: ready=1, mode 1: ready 1,0,0,1.
    task automatic stream8(input int mode, input bit restart_busy);
        int         k;
        int         cyc;
        bit         held;
        bit         seen_done;
        logic [7:0] hv;
        k = 0; cyc = 0; held = 0; seen_done = 0; hv = '0;
        while (cyc < 300 && !seen_done) begin
            if (done8) begin
                seen_done = 1;
                check("word_count", k, 20);
                check("done_valid", valid8, 0);
                check("done_busy", busy8, 0);
                if (mode == 0) check("latency", cyc, 20);
            end else begin
                if (held && valid8) check("stall_stable", data8, hv);
                if (mode == 0) ready8 = 1'b1;
                else           ready8 = ((cyc % 4) == 0) || ((cyc % 4) == 3);
                if (restart_busy) start8 = (cyc == 5);
                if (valid8 && ready8) begin
                    if (k < 20) begin
                        check($sformatf("word%0d", k), data8, exp8[k]);
                        check($sformatf("ez%0d", k), ez8, (k == 0));
                        check($sformatf("eo%0d", k), eo8, (k == 1));
                        check($sformatf("busy%0d", k), busy8, 1);
                    end else begin
                        check("extra_word", k, 19);
                    end
                    k++;
                    held = 0;
                end else if (valid8) begin
                    held = 1;
                    hv   = data8;
                end
                cyc++;
                @(negedge clk);
            end
        end
        start8 = 1'b0;
        check("done_seen", seen_done, 1);
    endtask

    task automatic pulse_start8();
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        start8 = 0; abort8 = 0; ready8 = 0;
        start2 = 0; abort2 = 0; ready2 = 0;
        repeat (2) @(negedge clk);
        check("rst_valid", valid8, 0);
        check("rst_data", data8, 0);
        check("rst_ez", ez8, 0);
        check("rst_eo", eo8, 0);
        check("rst_busy", busy8, 0);
        check("rst_done", done8, 0);
        reset = 1'b0;
        @(negedge clk);
        check("idle_ez", ez8, 0);

        // full throughput
        pulse_start8();
        check("start_valid", valid8, 1);
        check("start_busy", busy8, 1);
        stream8(0, 0);
        @(negedge clk);
        check("post_done", done8, 0);
        check("post_busy", busy8, 0);

        // backpressure
        pulse_start8();
        stream8(1, 0);
        @(negedge clk);

        // start re-pulsed while busy and during the done cycle
        pulse_start8();
        stream8(1, 1);
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        check("done_start_valid", valid8, 0);
        check("done_start_busy", busy8, 0);
        pulse_start8();
        check("restart_valid", valid8, 1);
        check("restart_data", data8, 8'h00);
        stream8(0, 0);
        @(negedge clk);

        // abort with ready on the third WALK1 word
        pulse_start8();
        ready8 = 1'b1;
        repeat (4) @(negedge clk);
        check("abort_word", data8, 8'h04);
        abort8 = 1'b1;
        @(negedge clk);
        abort8 = 1'b0;
        check("abort_valid", valid8, 0);
        check("abort_busy", busy8, 0);
        check("abort_done", done8, 0);
        @(negedge clk);
        check("abort_done2", done8, 0);
        pulse_start8();
        check("abort_restart_data", data8, 8'h00);
        check("abort_restart_ez", ez8, 1);
        check("abort_restart_valid", valid8, 1);

        // reset in the middle of WALK0
        repeat (12) @(negedge clk);
        check("mid_walk0_word", data8, 8'hFB);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mrst_valid", valid8, 0);
        check("mrst_data", data8, 0);
        check("mrst_ez", ez8, 0);
        check("mrst_eo", eo8, 0);
        check("mrst_busy", busy8, 0);
        check("mrst_done", done8, 0);
        @(negedge clk);
        check("mrst_done2", done8, 0);
        pulse_start8();
        stream8(0, 0);
        @(negedge clk);

        // WIDTH=2 instance
        ready2 = 1'b1;
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        for (int k = 0; k < 8; k++) begin
            check($sformatf("w2_valid%0d", k), valid2, 1);
            check($sformatf("w2_word%0d", k), data2, exp2[k]);
            check($sformatf("w2_ez%0d", k), ez2, (k == 0));
            check($sformatf("w2_eo%0d", k), eo2, (k == 1));
            @(negedge clk);
        end
        check("w2_done", done2, 1);
        check("w2_done_valid", valid2, 0);
        check("w2_done_busy", busy2, 0);
        @(negedge clk);
        check("w2_done_clear", done2, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
